// File: rtl/rfsoc_pl_ctrl_core.sv
// RFSoC PL control core: bit-serial GPIO configuration, per-channel DAC waveform
// players fed from a PS AXI-Stream, and per-channel ADC capture buffers with readout.
module rfsoc_pl_ctrl_core #(
    parameter int NUM_CH    = 16,
    parameter int CFG_W     = 16,
    parameter int MEM_DEPTH = 64,
    parameter int ADC_DEPTH = 16
) (
    input  logic                  pl_clk,
    input  logic                  rst,
    input  logic [15:0]           gpio_ctrl,
    input  logic [31:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [31:0]           adc_axis_tdata,
    output logic                  adc_axis_tvalid,
    input  logic                  adc_axis_tready,
    output logic [NUM_CH*256-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]     m_axis_tvalid,
    input  logic [NUM_CH-1:0]     m_axis_tready,
    input  logic [NUM_CH*128-1:0] s_adc_axis_tdata,
    input  logic [NUM_CH-1:0]     s_adc_axis_tvalid,
    output logic [NUM_CH-1:0]     s_adc_axis_tready
);
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int AAW = $clog2(ADC_DEPTH);
    localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [2:0] ST_LOAD = 3'd0, ST_IDLE = 3'd1, ST_PRE = 3'd2, ST_PLAY = 3'd3, ST_POST = 3'd4;

    logic [11:0]              sync1_q, sync2_q, sync3_q, rise;
    logic                     sdata, trig_q, trig_d, run_q, accept, wr_beat, found;
    logic [15:0]              chan_sel_q, chan_sel_d;
    logic [2:0]               wcnt_q, wcnt_d;
    logic [223:0]             wbuf_q, wbuf_d;
    logic [NUM_CH-1:0]        ld_ok, ch_avail, rd_adv;
    logic [NUM_CH-1:0][31:0]  ch_word;
    logic [SW-1:0]            src;
    logic                     unused_top;

    assign unused_top        = ^{m_axis_tready, gpio_ctrl[15:12]};
    assign m_axis_tvalid     = {NUM_CH{run_q}};
    assign s_adc_axis_tready = {NUM_CH{run_q}};
    assign s_axis_tready     = |ld_ok;

    always_comb begin
        rise       = sync2_q & ~sync3_q;
        sdata      = sync2_q[0];
        trig_d     = rise[1];
        chan_sel_d = rise[2] ? {sdata, chan_sel_q[15:1]} : chan_sel_q;
        accept     = s_axis_tvalid & s_axis_tready;
        wr_beat    = accept && (wcnt_q == 3'd7);
        wcnt_d     = accept ? wcnt_q + 3'd1 : wcnt_q;
        wbuf_d     = wbuf_q;
        if (accept && !wr_beat) wbuf_d[wcnt_q*32 +: 32] = s_axis_tdata;
    end

    // Readout follows the lowest-numbered selected channel.
    always_comb begin
        src   = '0;
        found = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (chan_sel_q[c]) begin
                src   = SW'(c);
                found = 1'b1;
            end
        end
        adc_axis_tvalid = found & ch_avail[src];
        adc_axis_tdata  = ch_word[src];
        rd_adv          = '0;
        rd_adv[src]     = adc_axis_tvalid & adc_axis_tready;
    end

    always_ff @(posedge pl_clk) begin
        if (!rst) begin
            sync1_q <= '0; sync2_q <= '0; sync3_q <= '0;
            trig_q <= 1'b0; chan_sel_q <= '0; wcnt_q <= '0; wbuf_q <= '0; run_q <= 1'b0;
        end else begin
            sync1_q <= gpio_ctrl[11:0]; sync2_q <= sync1_q; sync3_q <= sync2_q;
            trig_q <= trig_d; chan_sel_q <= chan_sel_d; wcnt_q <= wcnt_d; wbuf_q <= wbuf_d; run_q <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             sel, cap_q, cap_d, cap_on, store, start, last, unused_bits;
        logic [CFG_W-1:0] cyc_q, cyc_d, pre_q, pre_d, post_q, post_d, arun_q, arun_d, ash_q, ash_d;
        logic [CFG_W-1:0] cnt_q, cnt_d, lim;
        logic [255:0]     mask_q, mask_d, lock_q, lock_d, out_q, out_d, beat;
        logic [7:0]       mux_q, mux_d, men_q, men_d;
        logic [2:0]       st_q, st_d;
        logic [MAW:0]     wp_q, wp_d, rd_nx;
        logic [MAW-1:0]   rd_q, rd_d;
        logic [AAW:0]     wix_q, wix_d;
        logic [AAW+2:0]   rdp_q, rdp_d;
        logic [127:0]     sbeat;
        logic [255:0]     mem_q [MEM_DEPTH];
        logic [127:0]     adc_mem_q [ADC_DEPTH];

        assign sel                  = chan_sel_q[c];
        assign unused_bits          = ^{mux_q[7:1], men_q[7:1], ash_q[CFG_W-1:4]};
        assign ld_ok[c]             = sel && !mux_q[0] && (wp_q < (MAW+1)'(MEM_DEPTH));
        assign ch_avail[c]          = rdp_q < {wix_q, 2'b00};
        assign ch_word[c]           = adc_mem_q[rdp_q[AAW+1:2]][rdp_q[1:0]*32 +: 32];
        assign m_axis_tdata[c*256 +: 256] = out_q;

        always_comb begin
            cyc_d  = (sel && rise[3])  ? {sdata, cyc_q[CFG_W-1:1]}  : cyc_q;
            mask_d = (sel && rise[4])  ? {sdata, mask_q[255:1]}     : mask_q;
            pre_d  = (sel && rise[5])  ? {sdata, pre_q[CFG_W-1:1]}  : pre_q;
            post_d = (sel && rise[6])  ? {sdata, post_q[CFG_W-1:1]} : post_q;
            lock_d = (sel && rise[7])  ? {sdata, lock_q[255:1]}     : lock_q;
            mux_d  = (sel && rise[8])  ? {sdata, mux_q[7:1]}        : mux_q;
            men_d  = (sel && rise[9])  ? {sdata, men_q[7:1]}        : men_q;
            arun_d = (sel && rise[10]) ? {sdata, arun_q[CFG_W-1:1]} : arun_q;
            ash_d  = (sel && rise[11]) ? {sdata, ash_q[CFG_W-1:1]}  : ash_q;

            wp_d = wp_q;
            if (wr_beat && ld_ok[c]) wp_d = wp_q + 1'b1;
            if (mux_q[0] && !mux_d[0]) wp_d = '0;

            last  = (cnt_q == cyc_q - 1'b1);
            rd_nx = {1'b0, rd_q} + 1'b1;
            start = trig_q && (st_q == ST_IDLE);
            st_d  = st_q;
            cnt_d = cnt_q + 1'b1;
            rd_d  = rd_q;
            case (st_q)
                ST_LOAD: begin cnt_d = '0; st_d = ST_IDLE; end
                ST_IDLE: begin
                    cnt_d = '0;
                    rd_d  = '0;
                    if (trig_q)
                        st_d = (pre_q != '0) ? ST_PRE : (cyc_q != '0) ? ST_PLAY : (post_q != '0) ? ST_POST : ST_IDLE;
                end
                ST_PRE: if (cnt_q == pre_q - 1'b1) begin
                    cnt_d = '0;
                    st_d  = (cyc_q != '0) ? ST_PLAY : (post_q != '0) ? ST_POST : ST_IDLE;
                end
                ST_PLAY: begin
                    rd_d = (rd_nx >= wp_q) ? '0 : rd_nx[MAW-1:0];
                    if (last) begin
                        cnt_d = '0;
                        st_d  = (post_q != '0) ? ST_POST : ST_IDLE;
                    end
                end
                ST_POST: if (cnt_q == post_q - 1'b1) begin cnt_d = '0; st_d = ST_IDLE; end
                default: st_d = ST_IDLE;
            endcase
            if (!mux_q[0]) st_d = ST_LOAD;

            // A single-beat play is both first and last and so is fully masked.
            beat = (wp_q == '0) ? '0 : mem_q[rd_q];
            if (men_q[0] && cnt_q == '0) beat = beat & mask_q;
            if (men_q[0] && last)        beat = beat & ~mask_q;
            case (st_q)
                ST_PRE, ST_POST: out_d = '0;
                ST_PLAY:         out_d = beat;
                default:         out_d = lock_q;
            endcase

            lim    = (arun_q > CFG_W'(ADC_DEPTH)) ? CFG_W'(ADC_DEPTH) : arun_q;
            cap_on = cap_q || (st_q == ST_PLAY && cnt_q == '0);
            store  = cap_on && s_adc_axis_tvalid[c] && (CFG_W'(wix_q) < lim);
            sbeat  = '0;
            for (int j = 0; j < 8; j++)
                sbeat[j*16 +: 16] = 16'($signed(s_adc_axis_tdata[c*128 + j*16 +: 16]) >>> ash_q[3:0]);
            wix_d = store ? wix_q + 1'b1 : wix_q;
            cap_d = cap_on;
            rdp_d = rd_adv[c] ? rdp_q + 1'b1 : rdp_q;
            if (start) begin
                wix_d = '0;
                cap_d = 1'b0;
                rdp_d = '0;
            end
        end

        always_ff @(posedge pl_clk) begin
            if (!rst) begin
                cyc_q <= '0; mask_q <= '0; pre_q <= '0; post_q <= '0; lock_q <= '0;
                mux_q <= '0; men_q <= '0; arun_q <= '0; ash_q <= '0; wp_q <= '0;
                st_q <= ST_LOAD; cnt_q <= '0; rd_q <= '0; out_q <= '0;
                wix_q <= '0; rdp_q <= '0; cap_q <= 1'b0;
            end else begin
                cyc_q <= cyc_d; mask_q <= mask_d; pre_q <= pre_d; post_q <= post_d; lock_q <= lock_d;
                mux_q <= mux_d; men_q <= men_d; arun_q <= arun_d; ash_q <= ash_d; wp_q <= wp_d;
                st_q <= st_d; cnt_q <= cnt_d; rd_q <= rd_d; out_q <= out_d;
                wix_q <= wix_d; rdp_q <= rdp_d; cap_q <= cap_d;
            end
        end

        always_ff @(posedge pl_clk) begin
            if (wr_beat && ld_ok[c]) mem_q[wp_q[MAW-1:0]] <= {s_axis_tdata, wbuf_q};
            if (store) adc_mem_q[wix_q[AAW-1:0]] <= sbeat;
        end
    end
endmodule

// File: tb/tb_rfsoc_pl_ctrl_core.sv
// Scoreboard bench for rfsoc_pl_ctrl_core: expected DAC beats and ADC words are queued
// when stimulus is issued and checked by a monitor as the DUT produces them.
module tb_rfsoc_pl_ctrl_core;
    localparam int NUM_CH = 16;

    logic                  pl_clk = 1'b0;
    logic                  rst = 1'b0;
    logic [15:0]           gpio_ctrl = '0;
    logic [31:0]           s_axis_tdata = '0;
    logic                  s_axis_tvalid = 1'b0;
    logic                  s_axis_tready;
    logic [31:0]           adc_axis_tdata;
    logic                  adc_axis_tvalid;
    logic                  adc_axis_tready = 1'b1;
    logic [NUM_CH*256-1:0] m_axis_tdata;
    logic [NUM_CH-1:0]     m_axis_tvalid;
    logic [NUM_CH-1:0]     m_axis_tready = '1;
    logic [NUM_CH*128-1:0] s_adc_axis_tdata;
    logic [NUM_CH-1:0]     s_adc_axis_tvalid = '1;
    logic [NUM_CH-1:0]     s_adc_axis_tready;

    rfsoc_pl_ctrl_core dut (
        .pl_clk(pl_clk), .rst(rst), .gpio_ctrl(gpio_ctrl),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .adc_axis_tdata(adc_axis_tdata), .adc_axis_tvalid(adc_axis_tvalid), .adc_axis_tready(adc_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_adc_axis_tdata(s_adc_axis_tdata), .s_adc_axis_tvalid(s_adc_axis_tvalid),
        .s_adc_axis_tready(s_adc_axis_tready)
    );

    always #5 pl_clk = ~pl_clk;

    int cyc = 0;
    always @(posedge pl_clk) cyc <= cyc + 1;

    typedef struct { int cyc; int ch; logic [255:0] data; } dac_exp_t;
    dac_exp_t    dac_q[$];
    logic [31:0] adc_q[$];
    int          vectors = 0, miscompares = 0;
    logic [255:0] beats [5];
    logic [255:0] lock_v = {16{16'h1111}};
    logic [255:0] mask_v = {128'h0, {128{1'b1}}};
    // Hand-computed readout words: samples 1000..8000 (hex), raw and after >>>2.
    logic [31:0] raw_w [4] = '{32'h20001000, 32'h40003000, 32'h60005000, 32'h80007000};
    logic [31:0] sh2_w [4] = '{32'h08000400, 32'h10000C00, 32'h18001400, 32'hE0001C00};

    initial begin
        for (int c = 0; c < NUM_CH; c++)
            for (int j = 0; j < 8; j++) s_adc_axis_tdata[c*128 + j*16 +: 16] = 16'((j + 1) * 16'h1000);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge pl_clk) begin : mon
        dac_exp_t e;
        while (dac_q.size() > 0 && dac_q[0].cyc <= cyc) begin
            e = dac_q.pop_front();
            chk($sformatf("dac ch%0d cyc%0d", e.ch, e.cyc), m_axis_tdata[e.ch*256 +: 256], e.data);
        end
        if (adc_axis_tvalid && adc_axis_tready) begin
            if (adc_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL adc_unexpected: got %h want none", adc_axis_tdata);
            end else begin
                chk("adc_word", {224'd0, adc_axis_tdata}, {224'd0, adc_q.pop_front()});
            end
        end
    end

    task automatic shift_in(input int idx, input logic [255:0] val, input int w);
        for (int i = 0; i < w; i++) begin
            @(negedge pl_clk); gpio_ctrl[0] = val[i]; gpio_ctrl[idx] = 1'b0;
            @(negedge pl_clk); gpio_ctrl[idx] = 1'b1;
            @(negedge pl_clk);
        end
        @(negedge pl_clk); gpio_ctrl[idx] = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        s_axis_tdata = w;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 100) begin @(negedge pl_clk); n++; end
        if (n >= 100) chk("s_axis_tready timeout", {255'd0, s_axis_tready}, 256'd1);
        @(negedge pl_clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic push2(input int t, input logic [255:0] d);
        for (int ch = 0; ch < 2; ch++) begin
            dac_exp_t e;
            e.cyc = t; e.ch = ch; e.data = d;
            dac_q.push_back(e);
        end
    endtask

    // Trigger raised at negedge k: first framed beat is visible at negedge k+5.
    task automatic trigger(input int pre, input int post, input bit retrig, input bit sh2);
        int k, t;
        logic [255:0] b;
        @(negedge pl_clk);
        k = cyc;
        push2(k + 4, lock_v);
        t = k + 5;
        for (int i = 0; i < pre; i++) begin push2(t, '0); t++; end
        for (int n = 0; n < 10; n++) begin
            b = beats[n % 5];
            if (n == 0) b = b & mask_v;
            if (n == 9) b = b & ~mask_v;
            push2(t, b); t++;
        end
        for (int i = 0; i < post; i++) begin push2(t, '0); t++; end
        push2(t, lock_v);
        push2(t + 1, lock_v);
        for (int bt = 0; bt < 4; bt++)
            for (int i = 0; i < 4; i++) adc_q.push_back(sh2 ? sh2_w[i] : raw_w[i]);
        gpio_ctrl[1] = 1'b1;
        repeat (3) @(negedge pl_clk);
        gpio_ctrl[1] = 1'b0;
        if (retrig) begin
            repeat (5) @(negedge pl_clk);
            gpio_ctrl[1] = 1'b1;
            repeat (2) @(negedge pl_clk);
            gpio_ctrl[1] = 1'b0;
        end
        repeat (40) @(negedge pl_clk);
    endtask

    initial begin
        logic [31:0] w;
        int n;
        repeat (10) @(negedge pl_clk);
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("rst tdata ch%0d", c), m_axis_tdata[c*256 +: 256], '0);
        chk("rst tvalid", {240'd0, m_axis_tvalid}, '0);
        chk("rst adc_tvalid", {255'd0, adc_axis_tvalid}, '0);
        chk("rst s_axis_tready", {255'd0, s_axis_tready}, '0);
        rst = 1'b1;
        repeat (2) @(negedge pl_clk);
        chk("run tvalid", {240'd0, m_axis_tvalid}, {240'd0, 16'hFFFF});
        chk("run s_adc_tready", {240'd0, s_adc_axis_tready}, {240'd0, 16'hFFFF});
        chk("load lock ch0", m_axis_tdata[255:0], '0);

        shift_in(2, 256'h3, 16);
        repeat (4) @(negedge pl_clk);
        chk("load tready", {255'd0, s_axis_tready}, 256'd1);
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 8; k++) begin
                w = ((32'h11111111 * (10 + b)) & 32'hFFFFFFF0) | 32'(k);
                beats[b][k*32 +: 32] = w;
                send_word(w);
            end

        shift_in(3, 256'd10, 16);
        shift_in(5, 256'd2, 16);
        shift_in(6, 256'd2, 16);
        shift_in(4, mask_v, 256);
        shift_in(7, lock_v, 256);
        shift_in(9, 256'd1, 8);
        shift_in(10, 256'd4, 16);
        shift_in(11, 256'd2, 16);
        shift_in(8, 256'd1, 8);
        repeat (6) @(negedge pl_clk);
        chk("idle tready", {255'd0, s_axis_tready}, '0);
        chk("idle lock ch0", m_axis_tdata[255:0], lock_v);
        chk("idle lock ch1", m_axis_tdata[511:256], lock_v);
        chk("unselected ch2", m_axis_tdata[767:512], '0);

        repeat (4) trigger(2, 2, 1'b0, 1'b1);
        trigger(2, 2, 1'b1, 1'b1);
        shift_in(11, 256'd0, 16);
        shift_in(5, 256'd0, 16);
        shift_in(6, 256'd0, 16);
        repeat (4) @(negedge pl_clk);
        trigger(0, 0, 1'b0, 1'b0);

        n = 0;
        while ((dac_q.size() > 0 || adc_q.size() > 0) && n < 200) begin @(negedge pl_clk); n++; end
        chk("dac queue drained", 256'(dac_q.size()), '0);
        chk("adc queue drained", 256'(adc_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
